// File: rtl/apb_reg_slave_pkg.sv
// apb_reg_slave_pkg -- shared types and constants for the APB register slave.
//   apb_state_e : transfer FSM states (IDLE / ACCESS)
//   reg_idx_e   : register index decoded from PADDR[4:2]
//   decode widths and the wait-counter width
package apb_reg_slave_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_IRQ_PEND = 3'd2,
    REG_IRQ_MASK = 3'd3,
    REG_SCRATCH0 = 3'd4,
    REG_SCRATCH1 = 3'd5,
    REG_SCRATCH2 = 3'd6,
    REG_SCRATCH3 = 3'd7
  } reg_idx_e;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int NUM_REGS  = 8;
  localparam int IDX_LSB   = 2;   // PADDR[1:0] are byte lanes and ignored
  localparam int IDX_MSB   = 4;
  localparam int DEC_MSB   = 11;  // highest decoded address bit
  localparam int UNMAP_LSB = 5;   // PADDR[11:5] != 0 is outside the register block
  localparam int CNT_W     = 4;   // wait counter holds 0..15

endpackage

// File: rtl/apb_reg_slave_if.sv
// apb_reg_slave_if -- APB completer-side bus bundle.
//   psel_en, PENABLE, PWRITE, PADDR, PWDATA : requester -> completer
//   PRDATA, PREADY, PSLVERR                 : completer -> requester
// Handshake: the requester holds psel_en=1 with PENABLE=0 for one setup
// cycle, then raises PENABLE and keeps every request signal stable until
// it samples PREADY=1 at a rising edge; that edge ends the transfer.
// PRDATA and PSLVERR are meaningful only while PREADY=1.
interface apb_reg_slave_if;
  import apb_reg_slave_pkg::*;

  logic              psel_en;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output psel_en, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  psel_en, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_reg_slave.sv
// apb_reg_slave -- APB completer with eight 32-bit registers.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : APB slave modport (apb_reg_slave_if)
//   status_in  : hardware status, read-only at index 1
//   event_in   : per-bit event pulses setting IRQ_PEND bits
//   ctrl_out   : CTRL register contents
//   wr_strobe  : one-cycle pulse per register index after a write commits
//   irq        : registered OR of (IRQ_PEND & IRQ_MASK)
//   state      : current FSM state, for observation
// Build option: define APB_REG_SLAVE_WAIT_EN to insert WAIT_CYCLES access
// wait states; otherwise every transfer completes on its first access cycle.
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  apb_reg_slave_if.slave    bus,
  input  logic [DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0] event_in,
  output logic [DATA_W-1:0] ctrl_out,
  output logic [NUM_REGS-1:0] wr_strobe,
  output logic              irq,
  output apb_state_e        state
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range_check
    $error("apb_reg_slave: WAIT_CYCLES must be within 0..15");
  end

  apb_state_e state_q, state_d;
  reg_idx_e   idx;
  logic       unmapped, access_ok, ready, err, commit;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ctrl_q, pend_q, mask_q;
  logic [DATA_W-1:0] scratch_q [4];
  logic [DATA_W-1:0] w1c_mask;
  logic unused_addr;

  assign state       = state_q;
  assign idx         = reg_idx_e'(bus.PADDR[IDX_MSB:IDX_LSB]);
  assign unmapped    = |bus.PADDR[DEC_MSB:UNMAP_LSB];
  assign access_ok   = (state_q == ST_ACCESS) && bus.psel_en && bus.PENABLE;
  assign unused_addr = ^{bus.PADDR[ADDR_W-1:DEC_MSB+1], bus.PADDR[IDX_LSB-1:0]};

`ifdef APB_REG_SLAVE_WAIT_EN
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] cnt_q;

  assign ready = access_ok && (cnt_q == '0);

  // Loaded at the setup edge, then counts down once per ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && bus.psel_en && !bus.PENABLE) begin
      cnt_q <= WAIT_LOAD;
    end else if (state_q == ST_ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  assign ready = access_ok;
`endif

  // Unmapped addresses and writes to read-only STATUS complete with an error.
  assign err    = unmapped || (bus.PWRITE && idx == REG_STATUS);
  assign commit = ready && bus.PWRITE && !err;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. Dropping psel_en or PENABLE before PREADY aborts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.psel_en && !bus.PENABLE) state_d = ST_ACCESS;
      ST_ACCESS: if (ready || !(bus.psel_en && bus.PENABLE)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.PREADY  = ready;
    bus.PSLVERR = ready && err;
    bus.PRDATA  = '0;
    if (ready && !bus.PWRITE && !unmapped) bus.PRDATA = rd_data;
  end

  always_comb begin
    rd_data = '0;
    unique case (idx)
      REG_CTRL:     rd_data = ctrl_q;
      REG_STATUS:   rd_data = status_in;
      REG_IRQ_PEND: rd_data = pend_q;
      REG_IRQ_MASK: rd_data = mask_q;
      default:      rd_data = scratch_q[bus.PADDR[IDX_LSB+1:IDX_LSB]];
    endcase
  end

  assign w1c_mask = (commit && idx == REG_IRQ_PEND) ? bus.PWDATA : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
      wr_strobe <= '0;
      irq       <= 1'b0;
    end else begin
      // Events are ORed in after the clear, so a coincident event wins.
      pend_q    <= (pend_q & ~w1c_mask) | event_in;
      wr_strobe <= commit ? (NUM_REGS'(1) << idx) : '0;
      irq       <= |(pend_q & mask_q);
      if (commit) begin
        unique case (idx)
          REG_CTRL:     ctrl_q <= bus.PWDATA;
          REG_IRQ_MASK: mask_q <= bus.PWDATA;
          REG_SCRATCH0, REG_SCRATCH1, REG_SCRATCH2, REG_SCRATCH3:
            scratch_q[bus.PADDR[IDX_LSB+1:IDX_LSB]] <= bus.PWDATA;
          default: ;
        endcase
      end
    end
  end

  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
module tb_apb_reg_slave;
  import apb_reg_slave_pkg::*;

`ifdef APB_REG_SLAVE_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_reg_slave_if bus ();
  logic [31:0] status_in, event_in, ctrl_out;
  logic [7:0]  wr_strobe;
  logic        irq;
  apb_state_e  dut_state;

  apb_reg_slave #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .status_in(status_in), .event_in(event_in),
    .ctrl_out(ctrl_out), .wr_strobe(wr_strobe), .irq(irq), .state(dut_state)
  );

  // ---------------- reference model ----------------
  // Plain register file: index 1 is never stored (status_in is read live),
  // index 2 holds the pending bits.
  logic [31:0] mdl [8];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
  endtask

  function automatic bit is_unmapped(input logic [31:0] addr);
    return addr[11:5] != 7'd0;
  endfunction

  function automatic bit exp_err(input bit wr, input logic [31:0] addr);
    return is_unmapped(addr) || (wr && addr[4:2] == 3'd1);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] addr);
    if (is_unmapped(addr)) return 32'h0;
    if (addr[4:2] == 3'd1) return status_in;
    return mdl[addr[4:2]];
  endfunction

  // Applies a write to the model; returns the strobe expected next cycle.
  function automatic logic [7:0] mdl_write(input logic [31:0] addr, input logic [31:0] data);
    int i;
    if (exp_err(1'b1, addr)) return 8'h00;
    i = int'(addr[4:2]);
    if (i == 2) mdl[2] = mdl[2] & ~data;
    else        mdl[i] = data;
    return 8'h01 << i;
  endfunction

  // ---------------- driver tasks ----------------
  // One full transfer; acc = number of access cycles up to PREADY, -1 on timeout.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int acc);
    @(posedge clk); #1;
    bus.psel_en = 1'b1; bus.PENABLE = 1'b0;
    bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    acc = -1; rdata = 'x; err = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.PREADY === 1'b1) begin
        rdata = bus.PRDATA; err = bus.PSLVERR; acc = n;
        break;
      end
    end
  endtask

  // Transfer plus checks of latency, error flag and (for reads) data.
  task automatic xfer_chk(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [7:0] exp_strobe);
    logic [31:0] rd, exp_rd;
    logic        er;
    int          acc;
    exp_rd = wr ? 32'h0 : exp_read(addr);
    apb_xfer(wr, addr, wdata, rd, er, acc);
    chk({tag, "_latency"}, 32'(acc), 32'(EXP_WAIT + 1));
    chk({tag, "_pslverr"}, {31'h0, er}, {31'h0, exp_err(wr, addr)});
    chk({tag, "_prdata"}, rd, exp_rd);
    exp_strobe = wr ? mdl_write(addr, wdata) : 8'h00;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.psel_en = 1'b0; bus.PENABLE = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_all(input string tag);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) xfer_chk(tag, 1'b0, 32'(i * 4), 32'h0, s);
    idle_cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0]  s;
    logic [31:0] addr, data;
    bit          wr;

    bus.psel_en = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    status_in = 32'h0; event_in = 32'h0;
    mdl_reset();

    repeat (3) @(negedge clk);
    chk("rst_pready",  {31'h0, bus.PREADY},  32'h0);
    chk("rst_pslverr", {31'h0, bus.PSLVERR}, 32'h0);
    chk("rst_prdata",  bus.PRDATA, 32'h0);
    chk("rst_strobe",  {24'h0, wr_strobe}, 32'h0);
    chk("rst_irq",     {31'h0, irq}, 32'h0);
    chk("rst_ctrl",    ctrl_out, 32'h0);
    chk("rst_state",   32'(dut_state), 32'(ST_IDLE));
    rst = 1'b0;

    // CTRL write, strobe for exactly one cycle
    xfer_chk("ctrl_wr", 1'b1, 32'h000, 32'hDEADBEEF, s);
    idle_cycle();
    chk("ctrl_strobe", {24'h0, wr_strobe}, {24'h0, s});
    chk("ctrl_out", ctrl_out, 32'hDEADBEEF);
    @(negedge clk);
    chk("ctrl_strobe_gone", {24'h0, wr_strobe}, 32'h0);

    // STATUS read and illegal write
    status_in = 32'h12345678;
    xfer_chk("status_rd", 1'b0, 32'h004, 32'h0, s);
    xfer_chk("status_wr", 1'b1, 32'h004, 32'hFFFF0000, s);
    idle_cycle();
    chk("status_wr_strobe", {24'h0, wr_strobe}, 32'h0);

    // IRQ: mask bit 3, pulse event 3
    xfer_chk("mask_wr", 1'b1, 32'h00C, 32'h8, s);
    idle_cycle();
    @(posedge clk); #1; event_in = 32'h8;
    @(posedge clk); #1; event_in = 32'h0;
    mdl[2] = mdl[2] | 32'h8;
    repeat (3) @(negedge clk);
    chk("irq_set", {31'h0, irq}, 32'h1);
    // W1C coinciding with another event: set wins
    event_in = 32'h8;
    xfer_chk("w1c_race", 1'b1, 32'h008, 32'h8, s);
    mdl[2] = mdl[2] | 32'h8;
    idle_cycle();
    event_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    xfer_chk("pend_rd", 1'b0, 32'h008, 32'h0, s);
    // plain W1C clears
    xfer_chk("w1c_clr", 1'b1, 32'h008, 32'h8, s);
    idle_cycle();
    repeat (3) @(negedge clk);
    chk("irq_clr", {31'h0, irq}, 32'h0);

    // Unmapped accesses
    xfer_chk("unmap_wr", 1'b1, 32'h020, 32'hA5A5A5A5, s);
    idle_cycle();
    chk("unmap_strobe", {24'h0, wr_strobe}, 32'h0);
    xfer_chk("unmap_rd", 1'b0, 32'h020, 32'h0, s);
    read_all("after_unmap");

    // Reset during a write in progress
    @(posedge clk); #1;
    bus.psel_en = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h010; bus.PWDATA = 32'h55;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    if (EXP_WAIT >= 2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_state",  32'(dut_state), 32'(ST_IDLE));
    chk("midrst_pready", {31'h0, bus.PREADY}, 32'h0);
    chk("midrst_ctrl",   ctrl_out, 32'h0);
    bus.psel_en = 1'b0; bus.PENABLE = 1'b0;
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    // back-to-back read / write / read
    xfer_chk("b2b_rd0", 1'b0, 32'h010, 32'h0, s);
    xfer_chk("b2b_wr",  1'b1, 32'h010, 32'hCAFE0055, s);
    xfer_chk("b2b_rd1", 1'b0, 32'h010, 32'h0, s);
    idle_cycle();

    // Randomized transfers against the model
    for (int t = 0; t < 60; t++) begin
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      addr = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0,
              $urandom_range(0, 7) == 0 ? 7'($urandom_range(1, 127)) : 7'h0,
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) == 0) status_in = $urandom;
      xfer_chk("rand", wr, addr, data, s);
      if ($urandom_range(0, 1) == 1) begin
        idle_cycle();
        chk("rand_strobe", {24'h0, wr_strobe}, {24'h0, s});
      end
    end
    idle_cycle();
    read_all("final");
    chk("final_ctrl_out", ctrl_out, mdl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
